// File: rtl/lab2_proc_alu_bist_pkg.sv
// Shared types and constants for the ALU BIST sequencer.
// Optional directed-corner mode is enabled with ALU_BIST_DIRECTED_EN.
package lab2_proc_alu_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [3:0]  ALU_FN_LAST = 4'd12;

    // Feedback taps at bits 31,21,1,0 for both the LFSR and the MISR
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [31:0] MISR_TAPS   = 32'h8020_0003;
    localparam logic [31:0] IN1_XOR     = 32'h5A5A_5A5A;

    localparam int          N_CORNER    = 4;
    localparam logic [3:0][31:0] CORNER_IN0 = {32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    localparam logic [3:0][31:0] CORNER_IN1 = {32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};

    function automatic logic [31:0] shift_fb(input logic [31:0] x, input logic [31:0] taps);
        return {x[30:0], ^(x & taps)};
    endfunction

endpackage

// File: rtl/lab2_proc_AluBistMisr.sv
// 32-bit multiple-input signature register with synchronous clear and enable.
module lab2_proc_AluBistMisr
    import lab2_proc_alu_bist_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] sig,
    output logic [31:0] sig_nxt
);

    assign sig_nxt = shift_fb(sig, MISR_TAPS) ^ d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   sig <= '0;
        else if (clr) sig <= '0;
        else if (en)  sig <= sig_nxt;
    end

endmodule

// File: rtl/lab2_proc_alu_bist.sv
// BIST sequencer: sweeps ALU fn 0..12 with LFSR operands and compresses results into a MISR.
// Define ALU_BIST_DIRECTED_EN to replace the first vectors of each fn with corner operands.
module lab2_proc_alu_bist
    import lab2_proc_alu_bist_pkg::*;
#(
    parameter int          NUM_VECS   = 64,
    parameter logic [31:0] SEED       = 32'hACE1_2345,
    parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_val,
    output logic        start_rdy,
    output logic [31:0] in0,
    output logic [31:0] in1,
    output logic [3:0]  fn,
    input  logic [31:0] out,
    input  logic        ops_eq,
    input  logic        ops_lt,
    input  logic        ops_ltu,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature
);

    localparam int          CW       = (NUM_VECS > 1) ? $clog2(NUM_VECS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_VECS - 1);
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    state_e        state;
    logic [31:0]   lfsr;
    logic [3:0]    fn_r;
    logic [CW-1:0] cnt;
    logic [31:0]   vec_a, vec_b, sig_nxt, misr_d;
    logic          start_acc, last_vec, fn_last, lfsr_adv;

    assign start_acc = start_val && start_rdy;
    assign last_vec  = (cnt == CNT_LAST);
    assign fn_last   = (fn_r == ALU_FN_LAST);

`ifdef ALU_BIST_DIRECTED_EN
    logic       corner_vec;
    logic [1:0] cidx;
    assign corner_vec = (int'(cnt) < N_CORNER);
    assign cidx       = 2'(cnt);
    assign vec_a      = corner_vec ? CORNER_IN0[cidx] : lfsr;
    assign vec_b      = corner_vec ? CORNER_IN1[cidx] : ({lfsr[15:0], lfsr[31:16]} ^ IN1_XOR);
    assign lfsr_adv   = !corner_vec;
`else
    assign vec_a      = lfsr;
    assign vec_b      = {lfsr[15:0], lfsr[31:16]} ^ IN1_XOR;
    assign lfsr_adv   = 1'b1;
`endif

    // Operands are only driven onto the ALU while the sweep is running
    assign in0 = busy ? vec_a : '0;
    assign in1 = busy ? vec_b : '0;
    assign fn  = fn_r;

    assign misr_d = out ^ {29'b0, ops_eq, ops_lt, ops_ltu};

    lab2_proc_AluBistMisr u_misr (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_acc),
        .en      (busy),
        .d       (misr_d),
        .sig     (signature),
        .sig_nxt (sig_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lfsr      <= SEED_EFF;
            fn_r      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            start_rdy <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_acc) begin
                        state     <= RUN;
                        lfsr      <= SEED_EFF;
                        fn_r      <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        start_rdy <= 1'b0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                RUN: begin
                    if (lfsr_adv) lfsr <= shift_fb(lfsr, LFSR_TAPS);
                    if (last_vec) begin
                        cnt <= '0;
                        if (fn_last) begin
                            state     <= DONE;
                            fn_r      <= '0;
                            busy      <= 1'b0;
                            start_rdy <= 1'b1;
                            done      <= 1'b1;
                            pass      <= (sig_nxt == GOLDEN_SIG);
                        end else begin
                            fn_r <= fn_r + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab2_proc_alu_bist.sv
// Scoreboard bench for lab2_proc_alu_bist: behavioural ALU + signature model, queued expectations.
module tb_lab2_proc_alu_bist;

`ifdef ALU_BIST_DIRECTED_EN
    localparam bit DIR = 1'b1;
`else
    localparam bit DIR = 1'b0;
`endif
    localparam logic [31:0] SEED64 = 32'hACE1_2345;

    typedef struct { logic [3:0] fn; logic [31:0] a; logic [31:0] b; } vec_t;
    typedef struct { logic [31:0] sa; logic [31:0] sb; logic pa; logic pb; } res_t;

    function automatic logic [31:0] lstep(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    function automatic logic [31:0] corner_a(input int v);
        case (v)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return 32'h7FFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] corner_b(input int v);
        case (v)
            0: return 32'h0000_0000;
            2: return 32'h0000_0001;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return {31'b0, $signed(a) < $signed(b)};
            4'd6:  return {31'b0, a < b};
            4'd7:  return $unsigned($signed(a) >>> b[4:0]);
            4'd8:  return a >> b[4:0];
            4'd9:  return a << b[4:0];
            4'd10: return a;
            4'd11: return b;
            4'd12: return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [2:0] flags(input logic [31:0] a, input logic [31:0] b);
        return {a == b, $signed(a) < $signed(b), a < b};
    endfunction

    function automatic logic [31:0] calc_sig(input int nv, input logic [31:0] seed, input bit flt);
        logic [31:0] l, s, a, b, o;
        l = (seed == 32'h0) ? 32'h1 : seed;
        s = 32'h0;
        for (int f = 0; f < 13; f++) begin
            for (int v = 0; v < nv; v++) begin
                if (DIR && v < 4) begin
                    a = corner_a(v); b = corner_b(v);
                end else begin
                    a = l; b = {l[15:0], l[31:16]} ^ 32'h5A5A_5A5A; l = lstep(l);
                end
                o = alu(4'(f), a, b);
                if (flt && f == 2) o[5] = 1'b0;
                s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ (o ^ {29'b0, flags(a, b)});
            end
        end
        return s;
    endfunction

    localparam logic [31:0] GOLD = calc_sig(64, SEED64, 1'b0);

    logic clk = 1'b0;
    logic rst_n, s1, s64, fault;
    always #5 clk = ~clk;

    logic        o1_rdy, o1_busy, o1_done, o1_pass;
    logic [31:0] o1_in0, o1_in1, o1_sig, r1;
    logic [3:0]  o1_fn;
    logic [2:0]  f1;
    logic        a_rdy, a_busy, a_done, a_pass, b_rdy, b_busy, b_done, b_pass;
    logic [31:0] a_in0, a_in1, a_sig, b_in0, b_in1, b_sig, ra, rb;
    logic [3:0]  a_fn, b_fn;
    logic [2:0]  fa, fb;

    assign r1 = alu(o1_fn, o1_in0, o1_in1);
    assign f1 = flags(o1_in0, o1_in1);
    assign ra = alu(a_fn, a_in0, a_in1) & ((fault && a_fn == 4'd2) ? ~32'h20 : 32'hFFFF_FFFF);
    assign fa = flags(a_in0, a_in1);
    assign rb = alu(b_fn, b_in0, b_in1);
    assign fb = flags(b_in0, b_in1);

    lab2_proc_alu_bist #(.NUM_VECS(1), .SEED(32'h0), .GOLDEN_SIG(32'h0)) u1 (
        .clk(clk), .reset(rst_n), .start_val(s1), .start_rdy(o1_rdy),
        .in0(o1_in0), .in1(o1_in1), .fn(o1_fn), .out(r1),
        .ops_eq(f1[2]), .ops_lt(f1[1]), .ops_ltu(f1[0]),
        .busy(o1_busy), .done(o1_done), .pass(o1_pass), .signature(o1_sig));

    lab2_proc_alu_bist #(.NUM_VECS(64), .SEED(SEED64), .GOLDEN_SIG(GOLD)) u64 (
        .clk(clk), .reset(rst_n), .start_val(s64), .start_rdy(a_rdy),
        .in0(a_in0), .in1(a_in1), .fn(a_fn), .out(ra),
        .ops_eq(fa[2]), .ops_lt(fa[1]), .ops_ltu(fa[0]),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig));

    lab2_proc_alu_bist #(.NUM_VECS(64), .SEED(SEED64), .GOLDEN_SIG(GOLD ^ 32'h1)) u64x (
        .clk(clk), .reset(rst_n), .start_val(s64), .start_rdy(b_rdy),
        .in0(b_in0), .in1(b_in1), .fn(b_fn), .out(rb),
        .ops_eq(fb[2]), .ops_lt(fb[1]), .ops_ltu(fb[0]),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig));

    int total = 0;
    int bad   = 0;
    vec_t vq[$];
    vec_t q1[$];
    res_t rq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic gen_vecs(input int nv, input logic [31:0] seed, input bit to_u1);
        logic [31:0] l, a, b;
        l = (seed == 32'h0) ? 32'h1 : seed;
        for (int f = 0; f < 13; f++) begin
            for (int v = 0; v < nv; v++) begin
                if (DIR && v < 4) begin
                    a = corner_a(v); b = corner_b(v);
                end else begin
                    a = l; b = {l[15:0], l[31:16]} ^ 32'h5A5A_5A5A; l = lstep(l);
                end
                if (to_u1) q1.push_back('{fn: 4'(f), a: a, b: b});
                else       vq.push_back('{fn: 4'(f), a: a, b: b});
            end
        end
    endtask

    task automatic expect_run(input bit flt);
        res_t r;
        gen_vecs(64, SEED64, 1'b0);
        r.sa = calc_sig(64, SEED64, flt);
        r.sb = calc_sig(64, SEED64, 1'b0);
        r.pa = (r.sa == GOLD);
        r.pb = (r.sb == (GOLD ^ 32'h1));
        rq.push_back(r);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!a_busy && n < 10) begin @(negedge clk); n++; end
        if (!a_busy) chk("timeout_accept", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input bit hold);
        int n = 0;
        while (!a_done && n < 2000) begin
            s64 = hold ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk); n++;
        end
        if (!a_done) chk("timeout_done", 32'd0, 32'd1);
    endtask

    // Monitor: pops per-vector and per-run expectations as the DUT presents them
    int  bcnt  = 0;
    bit  dprev = 1'b0;
    initial forever begin
        vec_t v;
        res_t r;
        @(negedge clk);
        if (!rst_n) begin
            bcnt = 0; dprev = 1'b0;
        end else begin
            if (a_busy) begin
                bcnt++;
                if (vq.size() == 0) chk("vec_queue_empty", 32'd1, 32'd0);
                else begin
                    v = vq.pop_front();
                    chk("vec_fn", 32'(a_fn), 32'(v.fn));
                    chk("vec_in0", a_in0, v.a);
                    chk("vec_in1", a_in1, v.b);
                end
            end else if (bcnt != 0) begin
                chk("busy_span", 32'(bcnt), 32'd832);
                bcnt = 0;
            end
            if (a_done && !dprev) begin
                if (rq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    r = rq.pop_front();
                    chk("sig_a", a_sig, r.sa);
                    chk("pass_a", 32'(a_pass), 32'(r.pa));
                    chk("sig_b", b_sig, r.sb);
                    chk("pass_b", 32'(b_pass), 32'(r.pb));
                    chk("done_b", 32'(b_done), 32'd1);
                    chk("idle_in0", a_in0, 32'h0);
                end
            end
            dprev = a_done;
        end
    end

    initial begin
        vec_t v;
        int n;
        rst_n = 1'b0; s1 = 1'b0; s64 = 1'b0; fault = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 32'({o1_rdy, a_rdy, b_rdy}), 32'h7);
        chk("rst_busy", 32'({o1_busy, a_busy, b_busy}), 32'h0);
        chk("rst_done_pass", 32'({o1_done, a_done, o1_pass, a_pass}), 32'h0);
        chk("rst_sig", a_sig | o1_sig, 32'h0);
        chk("rst_fn", 32'({o1_fn, a_fn}), 32'h0);
        chk("rst_in", a_in0 | a_in1 | o1_in0, 32'h0);

        // NUM_VECS=1 with zero seed: one vector per fn, done 13 cycles after start
        gen_vecs(1, 32'h0, 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        for (int k = 0; k < 13; k++) begin
            v = q1.pop_front();
            chk("u1_fn", 32'(o1_fn), 32'(v.fn));
            chk("u1_in0", o1_in0, v.a);
            chk("u1_in1", o1_in1, v.b);
            chk("u1_busy_done", 32'({o1_busy, o1_done}), 32'h2);
            @(negedge clk);
        end
        chk("u1_done", 32'({o1_busy, o1_done, o1_rdy}), 32'h3);
        chk("u1_sig", o1_sig, calc_sig(1, 32'h0, 1'b0));
        chk("u1_pass", 32'(o1_pass), 32'(calc_sig(1, 32'h0, 1'b0) == 32'h0));

        // Normal run with random start_val noise during RUN
        expect_run(1'b0);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        s64 = 1'b1; @(negedge clk); wait_busy();
        wait_done(1'b0);
        s64 = 1'b0;

        // start_val held through RUN, then immediate restart from DONE
        expect_run(1'b0);
        expect_run(1'b0);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        s64 = 1'b1; @(negedge clk); wait_busy();
        wait_done(1'b1);
        @(negedge clk);
        chk("b2b_restart", 32'(a_busy), 32'd1);
        wait_done(1'b1);
        s64 = 1'b0;

        // Fault: out[5] forced low while fn==2
        expect_run(1'b1);
        fault = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        s64 = 1'b1; @(negedge clk); wait_busy();
        wait_done(1'b0);
        s64 = 1'b0;
        fault = 1'b0;

        // Async reset mid-run at fn==6, then a clean run
        expect_run(1'b0);
        s64 = 1'b1; @(negedge clk); s64 = 1'b0;
        n = 0;
        while (a_fn != 4'd6 && n < 2000) begin @(negedge clk); n++; end
        chk("reach_fn6", 32'(a_fn), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'({a_rdy, a_busy, a_done, a_pass}), 32'h8);
        chk("arst_sig", a_sig, 32'h0);
        chk("arst_ops", 32'(a_fn) | a_in0 | a_in1, 32'h0);
        vq.delete();
        rq.delete();
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 32'({a_rdy, a_busy}), 32'h2);
        expect_run(1'b0);
        s64 = 1'b1; @(negedge clk); wait_busy();
        wait_done(1'b0);
        s64 = 1'b0;

        repeat (3) @(negedge clk);
        chk("queues_drained", 32'(rq.size() + vq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
